// File: rtl/viterbi_cs_stage_pkg.sv
// Shared types and constants for the Viterbi compare-select stage.
// Holds the metric/path widths, state encodings and datapath typedefs.
package viterbi_pkg;
  localparam int MW = 4;
  localparam int PW = 8;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef logic [MW-1:0] metric_t;
  typedef logic [PW-1:0] path_t;
endpackage

// File: rtl/viterbi_cs_stage_if.sv
// Port bundle for the compare-select stage: FIRST lane (f_*) and STEADY lane (c_*).
// The master side drives candidate metrics and paths; the slave side returns the selected results.
interface viterbi_cs_stage_if;
  import viterbi_pkg::*;

  logic    f_valid_in;
  metric_t f_bm_00_0, f_bm_00_1, f_bm_01_0, f_bm_01_1;
  metric_t f_bm_10_0, f_bm_10_1, f_bm_11_0, f_bm_11_1;
  metric_t f_new_bm_00, f_new_bm_01, f_new_bm_10, f_new_bm_11;
  logic [2:0] f_sel_00, f_sel_01, f_sel_10, f_sel_11;
  logic    f_valid_out;

  logic    c_valid_in;
  metric_t c_bm_00_0, c_bm_00_1, c_bm_01_0, c_bm_01_1;
  metric_t c_bm_10_0, c_bm_10_1, c_bm_11_0, c_bm_11_1;
  path_t   c_path_00, c_path_01, c_path_10, c_path_11;
  metric_t c_new_bm_00, c_new_bm_01, c_new_bm_10, c_new_bm_11;
  path_t   c_new_path_00, c_new_path_01, c_new_path_10, c_new_path_11;
  logic    c_valid_out;

  modport master (
    output f_valid_in, f_bm_00_0, f_bm_00_1, f_bm_01_0, f_bm_01_1,
           f_bm_10_0, f_bm_10_1, f_bm_11_0, f_bm_11_1,
    input  f_new_bm_00, f_new_bm_01, f_new_bm_10, f_new_bm_11,
           f_sel_00, f_sel_01, f_sel_10, f_sel_11, f_valid_out,
    output c_valid_in, c_bm_00_0, c_bm_00_1, c_bm_01_0, c_bm_01_1,
           c_bm_10_0, c_bm_10_1, c_bm_11_0, c_bm_11_1,
           c_path_00, c_path_01, c_path_10, c_path_11,
    input  c_new_bm_00, c_new_bm_01, c_new_bm_10, c_new_bm_11,
           c_new_path_00, c_new_path_01, c_new_path_10, c_new_path_11, c_valid_out
  );

  modport slave (
    input  f_valid_in, f_bm_00_0, f_bm_00_1, f_bm_01_0, f_bm_01_1,
           f_bm_10_0, f_bm_10_1, f_bm_11_0, f_bm_11_1,
    output f_new_bm_00, f_new_bm_01, f_new_bm_10, f_new_bm_11,
           f_sel_00, f_sel_01, f_sel_10, f_sel_11, f_valid_out,
    input  c_valid_in, c_bm_00_0, c_bm_00_1, c_bm_01_0, c_bm_01_1,
           c_bm_10_0, c_bm_10_1, c_bm_11_0, c_bm_11_1,
           c_path_00, c_path_01, c_path_10, c_path_11,
    output c_new_bm_00, c_new_bm_01, c_new_bm_10, c_new_bm_11,
           c_new_path_00, c_new_path_01, c_new_path_10, c_new_path_11, c_valid_out
  );
endinterface

// File: rtl/viterbi_cs_stage_cs_pair.sv
// Combinational two-candidate minimum with decision bit (1 = branch 1 selected).
// Tie policy: branch 0 wins by default; VITERBI_CS_TIE_HIGH_EN makes branch 1 win.
module cs_pair
  import viterbi_pkg::*;
(
  input  metric_t bm_0,
  input  metric_t bm_1,
  output metric_t new_bm,
  output logic    dec
);
`ifdef VITERBI_CS_TIE_HIGH_EN
  assign dec = (bm_1 <= bm_0);
`else
  assign dec = (bm_1 < bm_0);
`endif
  assign new_bm = dec ? bm_1 : bm_0;
endmodule

// File: rtl/viterbi_cs_stage.sv
// Compare-select stage of a 4-state Viterbi decoder with independent FIRST and STEADY lanes.
// Tie policy selected by VITERBI_CS_TIE_HIGH_EN (undefined: branch 0 wins ties).
module viterbi_cs_stage
  import viterbi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  viterbi_cs_stage_if.slave  bus
);
  metric_t    f_b0 [4], f_b1 [4], f_min [4];
  metric_t    c_b0 [4], c_b1 [4], c_min [4];
  path_t      c_in [4];
  logic [3:0] f_d, c_d;

  metric_t    f_bm_p0 [4];
  logic [2:0] f_sel_p0 [4];
  metric_t    c_bm_p0 [4];
  path_t      c_path_p0 [4];
  logic       vld_f_p0, vld_c_p0;

  assign f_b0 = '{bus.f_bm_00_0, bus.f_bm_01_0, bus.f_bm_10_0, bus.f_bm_11_0};
  assign f_b1 = '{bus.f_bm_00_1, bus.f_bm_01_1, bus.f_bm_10_1, bus.f_bm_11_1};
  assign c_b0 = '{bus.c_bm_00_0, bus.c_bm_01_0, bus.c_bm_10_0, bus.c_bm_11_0};
  assign c_b1 = '{bus.c_bm_00_1, bus.c_bm_01_1, bus.c_bm_10_1, bus.c_bm_11_1};
  assign c_in = '{bus.c_path_00, bus.c_path_01, bus.c_path_10, bus.c_path_11};

  for (genvar s = 0; s < 4; s++) begin : g_cs
    cs_pair u_f (.bm_0(f_b0[s]), .bm_1(f_b1[s]), .new_bm(f_min[s]), .dec(f_d[s]));
    cs_pair u_c (.bm_0(c_b0[s]), .bm_1(c_b1[s]), .new_bm(c_min[s]), .dec(c_d[s]));
  end

  // p0: result registers; each lane's data loads only on its own valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_f_p0 <= 1'b0;
      vld_c_p0 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        f_bm_p0[i]   <= '0;
        f_sel_p0[i]  <= '0;
        c_bm_p0[i]   <= '0;
        c_path_p0[i] <= '0;
      end
    end else begin
      vld_f_p0 <= bus.f_valid_in;
      vld_c_p0 <= bus.c_valid_in;
      for (int i = 0; i < 4; i++) begin
        if (bus.f_valid_in) begin
          f_bm_p0[i]  <= f_min[i];
          f_sel_p0[i] <= {i[1:0], f_d[i]};
        end
        if (bus.c_valid_in) begin
          c_bm_p0[i]   <= c_min[i];
          c_path_p0[i] <= {c_in[i][PW-2:0], c_d[i]};
        end
      end
    end
  end

  assign bus.f_valid_out   = vld_f_p0;
  assign bus.f_new_bm_00   = f_bm_p0[0];
  assign bus.f_new_bm_01   = f_bm_p0[1];
  assign bus.f_new_bm_10   = f_bm_p0[2];
  assign bus.f_new_bm_11   = f_bm_p0[3];
  assign bus.f_sel_00      = f_sel_p0[0];
  assign bus.f_sel_01      = f_sel_p0[1];
  assign bus.f_sel_10      = f_sel_p0[2];
  assign bus.f_sel_11      = f_sel_p0[3];

  assign bus.c_valid_out   = vld_c_p0;
  assign bus.c_new_bm_00   = c_bm_p0[0];
  assign bus.c_new_bm_01   = c_bm_p0[1];
  assign bus.c_new_bm_10   = c_bm_p0[2];
  assign bus.c_new_bm_11   = c_bm_p0[3];
  assign bus.c_new_path_00 = c_path_p0[0];
  assign bus.c_new_path_01 = c_path_p0[1];
  assign bus.c_new_path_10 = c_path_p0[2];
  assign bus.c_new_path_11 = c_path_p0[3];
endmodule

// File: tb/tb_viterbi_cs_stage.sv
// Directed + pseudo-random bench for viterbi_cs_stage with a queue scoreboard.
// Honours VITERBI_CS_TIE_HIGH_EN for tie expectations.
module tb_viterbi_cs_stage;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_cs_stage_if bus();
  viterbi_cs_stage dut (.clk(clk), .rst(rst), .bus(bus));

  logic fv, cv;
  logic [3:0][3:0] fb0, fb1, cb0, cb1;
  logic [3:0][7:0] cp;

  assign bus.f_valid_in = fv;
  assign bus.f_bm_00_0 = fb0[0];  assign bus.f_bm_00_1 = fb1[0];
  assign bus.f_bm_01_0 = fb0[1];  assign bus.f_bm_01_1 = fb1[1];
  assign bus.f_bm_10_0 = fb0[2];  assign bus.f_bm_10_1 = fb1[2];
  assign bus.f_bm_11_0 = fb0[3];  assign bus.f_bm_11_1 = fb1[3];
  assign bus.c_valid_in = cv;
  assign bus.c_bm_00_0 = cb0[0];  assign bus.c_bm_00_1 = cb1[0];
  assign bus.c_bm_01_0 = cb0[1];  assign bus.c_bm_01_1 = cb1[1];
  assign bus.c_bm_10_0 = cb0[2];  assign bus.c_bm_10_1 = cb1[2];
  assign bus.c_bm_11_0 = cb0[3];  assign bus.c_bm_11_1 = cb1[3];
  assign bus.c_path_00 = cp[0];   assign bus.c_path_01 = cp[1];
  assign bus.c_path_10 = cp[2];   assign bus.c_path_11 = cp[3];

  wire [3:0][3:0] o_fbm  = {bus.f_new_bm_11, bus.f_new_bm_10, bus.f_new_bm_01, bus.f_new_bm_00};
  wire [3:0][2:0] o_fsel = {bus.f_sel_11, bus.f_sel_10, bus.f_sel_01, bus.f_sel_00};
  wire [3:0][3:0] o_cbm  = {bus.c_new_bm_11, bus.c_new_bm_10, bus.c_new_bm_01, bus.c_new_bm_00};
  wire [3:0][7:0] o_cp   = {bus.c_new_path_11, bus.c_new_path_10, bus.c_new_path_01, bus.c_new_path_00};

  typedef struct packed {
    logic            fv;
    logic [3:0][3:0] fbm;
    logic [3:0][2:0] fsel;
    logic            cv;
    logic [3:0][3:0] cbm;
    logic [3:0][7:0] cpath;
  } exp_t;

  exp_t model;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic dec(input logic [3:0] b0, input logic [3:0] b1);
`ifdef VITERBI_CS_TIE_HIGH_EN
    return (b1 <= b0);
`else
    return (b1 < b0);
`endif
  endfunction

  task automatic cmp(input string tag, input logic [31:0] o, input logic [31:0] e);
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_vs(input string tag, input exp_t e);
    cmp({tag, "_fvalid"}, 32'(bus.f_valid_out), 32'(e.fv));
    cmp({tag, "_fbm"},    32'(o_fbm),  32'(e.fbm));
    cmp({tag, "_fsel"},   32'(o_fsel), 32'(e.fsel));
    cmp({tag, "_cvalid"}, 32'(bus.c_valid_out), 32'(e.cv));
    cmp({tag, "_cbm"},    32'(o_cbm),  32'(e.cbm));
    cmp({tag, "_cpath"},  32'(o_cp),   32'(e.cpath));
  endtask

  // Push the expected registered result, clock once, then pop and compare.
  task automatic step(input string tag);
    exp_t e;
    n_vec++;
    model.fv = fv;
    model.cv = cv;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] ss;
      logic d;
      ss = s[1:0];
      if (fv) begin
        d = dec(fb0[s], fb1[s]);
        model.fbm[s]  = d ? fb1[s] : fb0[s];
        model.fsel[s] = {ss, d};
      end
      if (cv) begin
        d = dec(cb0[s], cb1[s]);
        model.cbm[s]   = d ? cb1[s] : cb0[s];
        model.cpath[s] = {cp[s][6:0], d};
      end
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check_vs(tag, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    fv = 1'b0; cv = 1'b0;
    fb0 = '0; fb1 = '0; cb0 = '0; cb1 = '0; cp = '0;
    model = '0;
    repeat (2) @(posedge clk);
    #1;
    check_vs("reset", '0);

    // Release; inputs change but stay unqualified, so outputs stay 0
    @(negedge clk);
    rst = 1'b0;
    fb0 = 16'h5A3C; fb1 = 16'h1234; cb0 = 16'h9876; cb1 = 16'h4321; cp = 32'hDEADBEEF;
    step("post_reset_idle");

    // FIRST basic
    fb0 = {4'd2, 4'd2, 4'd2, 4'd1};
    fb1 = {4'd3, 4'd1, 4'd4, 4'd3};
    fv = 1'b1;
    step("first_basic");
    cmp("first_basic_lit_bm",  32'(o_fbm),  32'({4'd2, 4'd1, 4'd2, 4'd1}));
    cmp("first_basic_lit_sel", 32'(o_fsel), 32'({3'b110, 3'b101, 3'b010, 3'b000}));

    // Ties
    fb0 = {4'd2, 4'd2, 4'd2, 4'd2};
    fb1 = {4'd2, 4'd2, 4'd2, 4'd2};
    step("first_tie");
`ifdef VITERBI_CS_TIE_HIGH_EN
    cmp("first_tie_lit_sel", 32'(o_fsel), 32'({3'b111, 3'b101, 3'b011, 3'b001}));
`else
    cmp("first_tie_lit_sel", 32'(o_fsel), 32'({3'b110, 3'b100, 3'b010, 3'b000}));
`endif

    // STEADY basic, FIRST lane idle and holding
    fv = 1'b0;
    cv = 1'b1;
    cb0 = {4'd4, 4'd2, 4'd3, 4'd1};
    cb1 = {4'd3, 4'd1, 4'd4, 4'd2};
    cp  = {8'h0F, 8'hF0, 8'hCC, 8'hAA};
    step("steady_basic");
    cmp("steady_lit_bm",   32'(o_cbm), 32'({4'd3, 4'd1, 4'd3, 4'd1}));
    cmp("steady_lit_path", 32'(o_cp),  32'({8'h1F, 8'hE1, 8'h98, 8'h54}));

    // Extremes on both lanes together
    fv = 1'b1;
    fb0 = {4'd15, 4'd0, 4'd15, 4'd0};
    fb1 = {4'd0, 4'd15, 4'd0, 4'd15};
    cb0 = {4'd1, 4'd1, 4'd1, 4'd1};
    cb1 = {4'd4, 4'd4, 4'd4, 4'd4};
    cp  = 32'hFFFF_FFFF;
    step("extremes");
    cmp("extremes_lit_sel",  32'(o_fsel), 32'({3'b111, 3'b100, 3'b011, 3'b000}));
    cmp("extremes_lit_path", 32'(o_cp),   32'hFEFE_FEFE);

    // Drop both valids: data must hold
    fv = 1'b0; cv = 1'b0;
    fb0 = 16'h7777; fb1 = 16'h1111; cb0 = 16'h8888; cb1 = 16'h2222; cp = 32'h1234_5678;
    step("hold");

    // Pseudo-random traffic with independent lane valids
    for (int k = 0; k < 24; k++) begin
      fv  = 1'($urandom_range(0, 1));
      cv  = 1'($urandom_range(0, 1));
      fb0 = 16'($urandom); fb1 = 16'($urandom);
      cb0 = 16'($urandom); cb1 = 16'($urandom);
      cp  = 32'($urandom);
      if (k % 6 == 0) fb1 = fb0;
      step("random");
    end

    // Asynchronous reset mid-cycle
    fv = 1'b1; cv = 1'b1;
    step("pre_reset");
    #2 rst = 1'b1;
    #1;
    model = '0;
    sb.delete();
    check_vs("async_reset", '0);
    @(negedge clk);
    rst = 1'b0;

    // Re-apply FIRST basic after release
    cv = 1'b0;
    fb0 = {4'd2, 4'd2, 4'd2, 4'd1};
    fb1 = {4'd3, 4'd1, 4'd4, 4'd3};
    fv = 1'b1;
    step("after_reset");
    cmp("after_reset_lit_sel", 32'(o_fsel), 32'({3'b110, 3'b101, 3'b010, 3'b000}));
    cmp("after_reset_lit_cbm", 32'(o_cbm),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
